// File: rtl/img_rx_stream_writer.sv
// Image stream writer: accepts a valid/ready pixel stream and writes each
// beat into the image SRAM at raster addresses. Channels are interleaved on
// the stream and steered to SRAM banks. Scan order is row-major or
// column-major, and a one-cycle done pulse marks the end of a frame.
module img_rx_stream_writer #(
  parameter int DATA_W = 8,
  parameter int ROW_W  = 8,
  parameter int COL_W  = 8,
  parameter int NCH    = 1,
  parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic              col_major,
  input  logic [ROW_W-1:0]  last_row,
  input  logic [COL_W-1:0]  last_col,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              busy,
  output logic              done,
  output logic              sram_sense_en,
  output logic              sram_we,
  output logic [CH_W-1:0]   sram_bank,
  output logic [ROW_W-1:0]  sram_row,
  output logic [COL_W-1:0]  sram_col,
  output logic [DATA_W-1:0] sram_din
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NCH - 1);

  state_t             state;
  logic [CH_W-1:0]    ch;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   cfg_last_row;
  logic [COL_W-1:0]   cfg_last_col;
  logic               cfg_col_major;

  logic accept;
  logic ch_last;
  logic row_last;
  logic col_last;
  logic frame_last;

  // Handshake and write strobe are combinational so the write lands in the
  // same cycle as the accept; abort suppresses ready immediately.
  assign s_ready       = (state == RUN) && !abort;
  assign accept        = s_valid && s_ready;
  assign busy          = (state == RUN);
  assign done          = (state == DONE);
  assign sram_sense_en = 1'b1;
  assign sram_we       = accept;
  assign sram_bank     = ch;
  assign sram_row      = row;
  assign sram_col      = col;
  assign sram_din      = s_data;

  assign ch_last    = (ch == CH_LAST);
  assign row_last   = (row == cfg_last_row);
  assign col_last   = (col == cfg_last_col);
  assign frame_last = ch_last && row_last && col_last;

  // Frame sequencer: latches config at start, walks channel -> inner -> outer
  // indices on each accepted beat, and emits a one-cycle DONE state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      ch            <= '0;
      row           <= '0;
      col           <= '0;
      cfg_last_row  <= '0;
      cfg_last_col  <= '0;
      cfg_col_major <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            cfg_last_row  <= last_row;
            cfg_last_col  <= last_col;
            cfg_col_major <= col_major;
            ch            <= '0;
            row           <= '0;
            col           <= '0;
            state         <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            ch    <= '0;
            row   <= '0;
            col   <= '0;
            state <= IDLE;
          end else if (accept) begin
            if (frame_last) begin
              ch    <= '0;
              row   <= '0;
              col   <= '0;
              state <= DONE;
            end else if (!ch_last) begin
              ch <= ch + CH_W'(1);
            end else begin
              ch <= '0;
              if (cfg_col_major) begin
                // Column-major: rows are the inner index.
                if (row_last) begin
                  row <= '0;
                  col <= col + COL_W'(1);
                end else begin
                  row <= row + ROW_W'(1);
                end
              end else begin
                // Row-major: columns are the inner index.
                if (col_last) begin
                  col <= '0;
                  row <= row + ROW_W'(1);
                end else begin
                  col <= col + COL_W'(1);
                end
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_img_rx_stream_writer.sv
// Bench for img_rx_stream_writer: two instances (NCH=1 and NCH=3) share the
// stimulus; only the selected one receives start. Expected write sequences
// come from nested raster loops over the frame geometry.
module tb_img_rx_stream_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       start;
  logic       abort;
  logic       col_major;
  logic [7:0] last_row;
  logic [7:0] last_col;
  logic       s_valid;
  logic [7:0] s_data;
  logic       sel;

  logic       rdy1, busy1, done1, sen1, we1;
  logic [0:0] bank1;
  logic [7:0] row1, col1, din1;
  logic       rdy3, busy3, done3, sen3, we3;
  logic [1:0] bank3;
  logic [7:0] row3, col3, din3;

  img_rx_stream_writer #(.DATA_W(8), .ROW_W(8), .COL_W(8), .NCH(1)) dut1 (
    .clk(clk), .rstn(rstn), .start(start & ~sel), .abort(abort),
    .col_major(col_major), .last_row(last_row), .last_col(last_col),
    .s_valid(s_valid & ~sel), .s_data(s_data), .s_ready(rdy1),
    .busy(busy1), .done(done1), .sram_sense_en(sen1), .sram_we(we1),
    .sram_bank(bank1), .sram_row(row1), .sram_col(col1), .sram_din(din1)
  );

  img_rx_stream_writer #(.DATA_W(8), .ROW_W(8), .COL_W(8), .NCH(3)) dut3 (
    .clk(clk), .rstn(rstn), .start(start & sel), .abort(abort),
    .col_major(col_major), .last_row(last_row), .last_col(last_col),
    .s_valid(s_valid & sel), .s_data(s_data), .s_ready(rdy3),
    .busy(busy3), .done(done3), .sram_sense_en(sen3), .sram_we(we3),
    .sram_bank(bank3), .sram_row(row3), .sram_col(col3), .sram_din(din3)
  );

  // Observed view of the selected instance
  logic       o_ready, o_busy, o_done, o_sen, o_we;
  logic [1:0] o_bank;
  logic [7:0] o_row, o_col, o_din;
  always_comb begin
    o_ready = sel ? rdy3  : rdy1;
    o_busy  = sel ? busy3 : busy1;
    o_done  = sel ? done3 : done1;
    o_sen   = sel ? sen3  : sen1;
    o_we    = sel ? we3   : we1;
    o_bank  = sel ? bank3 : {1'b0, bank1};
    o_row   = sel ? row3  : row1;
    o_col   = sel ? col3  : col1;
    o_din   = sel ? din3  : din1;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int bank;
    int row;
    int col;
  } addr_t;

  addr_t exp_q[$];

  // Reference raster order: outer index, inner index, then channel.
  task automatic build_order(input int nch, input int lr, input int lc, input bit cm);
    addr_t a;
    exp_q.delete();
    if (!cm) begin
      for (int r = 0; r <= lr; r++)
        for (int c = 0; c <= lc; c++)
          for (int k = 0; k < nch; k++) begin
            a.bank = k; a.row = r; a.col = c; exp_q.push_back(a);
          end
    end else begin
      for (int c = 0; c <= lc; c++)
        for (int r = 0; r <= lr; r++)
          for (int k = 0; k < nch; k++) begin
            a.bank = k; a.row = r; a.col = c; exp_q.push_back(a);
          end
    end
  endtask

  // stop_kind: 0 = full frame, 1 = abort after stop_at beats, 2 = reset after stop_at beats
  task automatic run_frame(input bit s3, input int lr, input int lc, input bit cm,
                           input int duty, input int seq_base,
                           input int stop_at, input int stop_kind);
    int    accepted;
    int    cycles;
    addr_t e;
    logic [7:0] d;
    accepted = 0;
    cycles   = 0;
    build_order(s3 ? 3 : 1, lr, lc, cm);
    @(negedge clk);
    sel = s3; last_row = 8'(lr); last_col = 8'(lc); col_major = cm;
    start = 1'b1; abort = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("busy_run", o_busy, 1);
    while (exp_q.size() > 0) begin
      cycles++;
      if (cycles > 2000) begin
        check("timeout", 0, 1);
        exp_q.delete();
        return;
      end
      // Config and start wiggle during RUN must not matter
      last_row  = 8'($urandom);
      last_col  = 8'($urandom);
      col_major = 1'($urandom);
      start     = 1'($urandom);
      if (stop_kind != 0 && accepted == stop_at) begin
        start = 1'b0;
        s_valid = 1'b1;
        s_data = 8'($urandom);
        if (stop_kind == 1) begin
          abort = 1'b1;
          #1;
          check("abort_we", o_we, 0);
          check("abort_ready", o_ready, 0);
          @(negedge clk);
          abort = 1'b0;
          s_valid = 1'b0;
          check("abort_busy", o_busy, 0);
          check("abort_done", o_done, 0);
        end else begin
          rstn = 1'b0;
          #1;
          check("rst_busy", o_busy, 0);
          check("rst_ready", o_ready, 0);
          check("rst_we", o_we, 0);
          check("rst_done", o_done, 0);
          @(negedge clk);
          rstn = 1'b1;
          s_valid = 1'b0;
        end
        exp_q.delete();
        return;
      end
      s_valid = ($urandom_range(0, 99) < duty);
      d = (seq_base >= 0) ? 8'(seq_base + accepted) : 8'($urandom);
      s_data = d;
      #1;
      check("ready", o_ready, 1);
      check("done_low", o_done, 0);
      check("we", o_we, s_valid);
      if (s_valid) begin
        e = exp_q.pop_front();
        check("bank", o_bank, e.bank);
        check("row", o_row, e.row);
        check("col", o_col, e.col);
        check("din", o_din, d);
        $display("write #%0d bank=%0d row=%0d col=%0d din=%0d", accepted, o_bank, o_row, o_col, o_din);
        accepted++;
      end
      @(negedge clk);
    end
    // DONE cycle: start and s_valid asserted must be ignored
    start = 1'b1;
    s_valid = 1'b1;
    #1;
    check("done_pulse", o_done, 1);
    check("done_busy", o_busy, 0);
    check("done_ready", o_ready, 0);
    check("done_we", o_we, 0);
    @(negedge clk);
    start = 1'b0;
    s_valid = 1'b0;
    check("post_done", o_done, 0);
    check("post_busy", o_busy, 0);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; col_major = 1'b0;
    last_row = '0; last_col = '0; s_valid = 1'b1; s_data = '0; sel = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy0", o_busy, 0);
    check("rst_done0", o_done, 0);
    check("rst_ready0", o_ready, 0);
    check("rst_we0", o_we, 0);
    check("sense_en", o_sen, 1);
    rstn = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);

    // start together with abort in IDLE does not launch a frame
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("idle_abort_busy", o_busy, 0);

    run_frame(1'b0, 1, 2, 1'b0, 100, 1, -1, 0);
    run_frame(1'b0, 1, 2, 1'b1, 100, 1, -1, 0);
    run_frame(1'b1, 0, 1, 1'b0, 100, 10, -1, 0);
    run_frame(1'b0, 3, 3, 1'b0, 50, -1, -1, 0);
    run_frame(1'b0, 1, 2, 1'b0, 100, -1, 3, 1);
    run_frame(1'b0, 1, 2, 1'b0, 100, -1, -1, 0);
    run_frame(1'b0, 3, 3, 1'b1, 100, -1, 5, 2);
    run_frame(1'b0, 0, 0, 1'b0, 100, -1, -1, 0);
    for (int i = 0; i < 8; i++) begin
      run_frame(1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), 60, -1, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/img_rx_stream_writer.md
Name: img_rx_stream_writer

Overview:
Parametrised successor to the single-channel SRAM image writer. It accepts a valid/ready pixel stream and writes each beat into the image SRAM at raster addresses. It supports configurable data/address widths, multiple interleaved channels mapped to SRAM banks, and row-major or column-major scan order. It sits between the IO receive path and the image SRAM, ahead of the convolution engine, and reports frame completion with a done pulse.

Parameters:
DATA_W, 8, pixel/channel sample width
ROW_W, 8, row index width
COL_W, 8, column index width
NCH, 1, channels per pixel, interleaved on the stream; channel k is written to bank k
CH_W, (NCH>1 ? $clog2(NCH) : 1), bank select width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  begin frame; sampled only in IDLE
abort  in  1  terminate the frame; returns to IDLE
col_major  in  1  scan order: 0 = row-major, 1 = column-major; latched at start
last_row  in  ROW_W  index of the final row (nrows-1); latched at start
last_col  in  COL_W  index of the final column (ncols-1); latched at start
s_valid  in  1  stream beat valid
s_data  in  DATA_W  stream beat data
s_ready  out  1  writer can accept a beat
busy  out  1  frame in progress
done  out  1  one-cycle pulse after the final beat is written
sram_sense_en  out  1  SRAM sense enable
sram_we  out  1  SRAM write enable
sram_bank  out  CH_W  SRAM bank (channel) select
sram_row  out  ROW_W  SRAM row address
sram_col  out  COL_W  SRAM column address
sram_din  out  DATA_W  SRAM write data

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE; ch/row/col counters=0; latched config=0; busy=0, done=0. Therefore s_ready=0 and sram_we=0.
- sram_sense_en is constant 1.
- FSM states: IDLE, RUN, DONE.
- IDLE: on start=1 (with abort=0), latch last_row, last_col and col_major, clear counters, and go to RUN next cycle. abort in IDLE has no effect.
- RUN: busy=1 and s_ready = !abort.
- Beat accept: a beat is accepted when s_valid && s_ready.
  - The write happens in the same cycle: sram_we=1, sram_bank=ch, sram_row=row, sram_col=col, sram_din=s_data.
  - There are zero cycles of latency from handshake to write. sram_we=0 on every cycle without an accept.
- Counter advance on accept:
  - ch increments first. At ch==NCH-1, ch wraps to 0 and the inner index advances.
  - Inner index is col for row-major, row for column-major. At its last value it wraps to 0 and the outer index increments.
- Final beat: ch==NCH-1, row==last_row and col==last_col. On accept, the write occurs, counters clear, and the FSM goes to DONE.
- DONE: lasts one cycle with done=1, busy=0, s_ready=0, then returns to IDLE. A start during DONE is ignored.
- abort in RUN:
  - s_ready is forced to 0 that cycle, so no write occurs.
  - Next state is IDLE with counters cleared and no done pulse.
- start while RUN or DONE: ignored.
- Config inputs changing during RUN: ignored; the latched values are used.
- Beat count per frame is NCH*(last_row+1)*(last_col+1).
- Degenerate frame: last_row=0, last_col=0, NCH=1 gives exactly one write.
- Counters never exceed the latched bounds. No beat is accepted outside RUN.
- done and busy are never high together.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values. The next frame starts from address (0,0,0).

Test Plan:
- NCH=1, last_row=1, last_col=2, row-major, s_valid held high, data 1..6 -> writes at (r,c) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) with din 1..6 on 6 consecutive cycles; done pulses once on the cycle after the 6th write; busy then drops.
- Same frame with col_major=1 -> write order is (0,0),(1,0),(0,1),(1,1),(0,2),(1,2).
- NCH=3, 1x2 frame, data 10..15 -> (bank,col) sequence is (0,0),(1,0),(2,0),(0,1),(1,1),(2,1) with din 10..15; row stays 0.
- Random s_valid gaps (about 50% duty) on a 4x4 frame -> exactly 16 writes, in order, one per accepted beat; sram_we=0 whenever s_valid=0.
- abort asserted with s_valid=1 after the 3rd beat of a 2x3 frame -> no write that cycle, no done, IDLE next cycle. A following start rewrites from (0,0).
- rstn pulsed low mid-frame, then a 1x1 frame (last_row=0, last_col=0) -> outputs reset immediately; the new frame produces one write at (0,0) followed by a single done pulse.
